// File: rtl/pong_pkg.sv
// Shared types and constants for the pong frame builder: frame layout,
// colour byte positions, FSM states and the latched game snapshot.
package pong_pkg;

    localparam int MATRIX_DIM = 8;

    localparam int RED_HI = 23;
    localparam int GRN_HI = 15;
    localparam int BLU_HI = 7;

    typedef logic [23:0]      row_t;
    typedef row_t [7:0]       frame_t;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        RENDER,
        SWAP
    } builder_state_t;

    // Paddle tops are widened to 4 bits so top + length - 1 never wraps.
    typedef struct packed {
        logic [3:0] p1;
        logic [3:0] p2;
        logic [2:0] ball_x;
        logic [2:0] ball_y;
        logic       game_over;
        logic       winner;
    } shadow_t;

endpackage

// File: rtl/pong_row_render.sv
// Combinational renderer for one matrix row from the latched game snapshot.
module pong_row_render
    import pong_pkg::*;
#(
    parameter int PADDLE_LEN = 3
) (
    input  logic [2:0] row_idx,
    input  shadow_t    shadow,
    output row_t       row
);

    localparam logic [3:0] LEN4 = 4'(PADDLE_LEN);

    logic [3:0] r4;
    logic [7:0] red;
    logic [7:0] grn;
    logic [7:0] blu;

    assign r4 = {1'b0, row_idx};

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        red = 8'h00;
        grn = 8'h00;
        blu = 8'h00;
        if (shadow.game_over) begin
            if (shadow.winner) blu = 8'hFF;
            else               red = 8'hFF;
        end else begin
            if (r4 >= shadow.p1 && r4 <= shadow.p1 + LEN4 - 4'd1) red[0] = 1'b1;
            if (r4 >= shadow.p2 && r4 <= shadow.p2 + LEN4 - 4'd1) blu[7] = 1'b1;
            if (row_idx == shadow.ball_y) grn = 8'd1 << shadow.ball_x;
        end
    end

    always_comb begin
        row = '0;
        row[RED_HI -: 8] = red;
        row[GRN_HI -: 8] = grn;
        row[BLU_HI -: 8] = blu;
    end

endmodule

// File: rtl/pong_frame_builder.sv
// Double-buffered 8x8 RGB frame builder: latch game state, render one row per
// clock into a back buffer, then swap it atomically onto the front buffer.
module pong_frame_builder
    import pong_pkg::*;
#(
    parameter int PADDLE_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       update_req,
    input  logic [2:0] paddle1_pos,
    input  logic [2:0] paddle2_pos,
    input  logic [2:0] ball_x,
    input  logic [2:0] ball_y,
    input  logic       game_over,
    input  logic       winner,
    output frame_t     frame,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [3:0] POS_MAX = 4'(MATRIX_DIM - PADDLE_LEN);

    builder_state_t state_q, state_d;
    logic [2:0]     row_q;
    logic           pending;
    shadow_t        shadow;
    frame_t         back;
    row_t           row_pix;
    logic           latch_en, render_en, swap_en;

    function automatic logic [3:0] clamp_pos(input logic [2:0] pos);
        return ({1'b0, pos} > POS_MAX) ? POS_MAX : {1'b0, pos};
    endfunction

    pong_row_render #(.PADDLE_LEN(PADDLE_LEN)) u_row_render (
        .row_idx (row_q),
        .shadow  (shadow),
        .row     (row_pix)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (update_req || pending) state_d = LATCH;
            LATCH:   state_d = RENDER;
            RENDER:  if (row_q == 3'd7) state_d = SWAP;
            SWAP:    state_d = (update_req || pending) ? LATCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        latch_en  = (state_q == LATCH);
        render_en = (state_q == RENDER);
        swap_en   = (state_q == SWAP);
    end

    // NOTE: both buffers are reset so an interrupted render leaves the matrix dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            back       <= '0;
            frame      <= '0;
            row_q      <= 3'd0;
            pending    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            busy       <= (state_d != IDLE);
            frame_done <= swap_en;

            // A request in SWAP re-enters LATCH directly, so only RENDER needs to remember one.
            if (latch_en) begin
                shadow.p1        <= clamp_pos(paddle1_pos);
                shadow.p2        <= clamp_pos(paddle2_pos);
                shadow.ball_x    <= ball_x;
                shadow.ball_y    <= ball_y;
                shadow.game_over <= game_over;
                shadow.winner    <= winner;
                row_q            <= 3'd0;
                pending          <= update_req;
            end else if (render_en && update_req) begin
                pending <= 1'b1;
            end

            if (render_en) begin
                back[row_q] <= row_pix;
                row_q       <= row_q + 3'd1;
            end

            if (swap_en) frame <= back;
        end
    end

endmodule
